// File: rtl/multi_cycle_cu.sv
// Multi-cycle control sequencer for a MIPS-subset core with a shared ALU and a
// unified memory port. Moore FSM with mem_ready handshakes and a retire counter.
module multi_cycle_cu #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             branch,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             wreg_dst_sel,
  output logic             wrbck_sel,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_debug
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state;
  state_t state_next;

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Moore outputs (FETCH/MEMWR handshakes qualified by mem_ready)
  always_comb begin
    pc_we        = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    wreg_dst_sel = 1'b0;
    wrbck_sel    = 1'b0;
    alu_srca     = 1'b0;
    alu_srcb     = 2'b00;
    aluop        = 2'b00;
    pc_src       = 2'b00;
    retire       = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd   = 1'b1;
        alu_srcb = 2'b01;
        ir_we    = mem_ready;
        pc_we    = mem_ready;
      end
      S_DECODE: begin
        alu_srcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        reg_we    = 1'b1;
        wrbck_sel = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
        retire = mem_ready;
      end
      S_EXECUTE: begin
        alu_srca = 1'b1;
        aluop    = 2'b10;
      end
      S_ALUWB: begin
        reg_we       = 1'b1;
        wreg_dst_sel = 1'b1;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        alu_srca = 1'b1;
        aluop    = 2'b01;
        pc_src   = 2'b01;
        branch   = 1'b1;
        retire   = 1'b1;
      end
      S_ADDIEX: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
      end
      S_ADDIWB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk) begin
    if (reset)       retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  end

  assign state_debug = state;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Bench for multi_cycle_cu: per-cycle vector table with a scoreboard queue,
// plus a hand-written sw stall sequence. Two instances (32-bit and 4-bit counter).
module tb_multi_cycle_cu;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic       pc_we;
    logic       branch;
    logic       iord;
    logic       mem_rd;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       wreg_dst_sel;
    logic       wrbck_sel;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       retire;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] cnt;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  ctl_t        act, act4;
  logic [31:0] cnt32;
  logic [3:0]  cnt4;
  logic [3:0]  st, st4;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  exp_t sb[$];
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  multi_cycle_cu dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(act.pc_we), .branch(act.branch), .iord(act.iord), .mem_rd(act.mem_rd),
    .mem_we(act.mem_we), .ir_we(act.ir_we), .reg_we(act.reg_we),
    .wreg_dst_sel(act.wreg_dst_sel), .wrbck_sel(act.wrbck_sel), .alu_srca(act.alu_srca),
    .alu_srcb(act.alu_srcb), .aluop(act.aluop), .pc_src(act.pc_src), .retire(act.retire),
    .illegal_op(act.illegal_op), .retired_cnt(cnt32), .state_debug(st)
  );

  multi_cycle_cu #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(act4.pc_we), .branch(act4.branch), .iord(act4.iord), .mem_rd(act4.mem_rd),
    .mem_we(act4.mem_we), .ir_we(act4.ir_we), .reg_we(act4.reg_we),
    .wreg_dst_sel(act4.wreg_dst_sel), .wrbck_sel(act4.wrbck_sel), .alu_srca(act4.alu_srca),
    .alu_srcb(act4.alu_srcb), .aluop(act4.aluop), .pc_src(act4.pc_src), .retire(act4.retire),
    .illegal_op(act4.illegal_op), .retired_cnt(cnt4), .state_debug(st4)
  );

  // Expected control word for a state, written from the per-state output table
  function automatic ctl_t exp_ctl(input logic [3:0] s, input logic rdy, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.mem_rd = 1'b1; c.alu_srcb = 2'b01; c.ir_we = rdy; c.pc_we = rdy; end
      4'd1:  begin
        c.alu_srcb = 2'b11;
        c.illegal_op = !(op == OP_LW || op == OP_SW || op == OP_R ||
                         op == OP_BEQ || op == OP_ADD || op == OP_J);
      end
      4'd2:  begin c.alu_srca = 1'b1; c.alu_srcb = 2'b10; end
      4'd3:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.reg_we = 1'b1; c.wrbck_sel = 1'b1; c.retire = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.mem_we = 1'b1; c.retire = rdy; end
      4'd6:  begin c.alu_srca = 1'b1; c.aluop = 2'b10; end
      4'd7:  begin c.reg_we = 1'b1; c.wreg_dst_sel = 1'b1; c.retire = 1'b1; end
      4'd8:  begin c.alu_srca = 1'b1; c.aluop = 2'b01; c.pc_src = 2'b01;
                   c.branch = 1'b1; c.retire = 1'b1; end
      4'd9:  begin c.alu_srca = 1'b1; c.alu_srcb = 2'b10; end
      4'd10: begin c.reg_we = 1'b1; c.retire = 1'b1; end
      4'd11: begin c.pc_src = 2'b10; c.pc_we = 1'b1; c.retire = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] s);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = s;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Scoreboard consumer: compare DUT outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("state[%0d]", e.idx), 32'(st), 32'(e.st));
      check($sformatf("ctl[%0d]", e.idx), 32'(act), 32'(e.ctl));
      check($sformatf("ctl4[%0d]", e.idx), 32'(act4), 32'(e.ctl));
      check($sformatf("cnt32[%0d]", e.idx), cnt32, e.cnt);
      check($sformatf("cnt4[%0d]", e.idx), 32'(cnt4), 32'(e.cnt[3:0]));
    end
  end

  initial begin
    int n, cyc, we_cnt, ret_cnt;
    reset = 1'b1; opcode = OP_R; mem_ready = 1'b0;

    // Reset held: FETCH values, handshakes off
    add(1, OP_R, 0, 0);
    // lw with two stall cycles in MEMRD
    add(0, OP_LW, 1, 0); add(0, OP_LW, 1, 1); add(0, OP_LW, 1, 2);
    add(0, OP_LW, 0, 3); add(0, OP_LW, 0, 3); add(0, OP_LW, 1, 3); add(0, OP_LW, 1, 4);
    // Mixed stream R, addi, beq, j
    add(0, OP_R, 1, 0);   add(0, OP_R, 1, 1);   add(0, OP_R, 1, 6);   add(0, OP_R, 1, 7);
    add(0, OP_ADD, 1, 0); add(0, OP_ADD, 1, 1); add(0, OP_ADD, 1, 9); add(0, OP_ADD, 1, 10);
    add(0, OP_BEQ, 1, 0); add(0, OP_BEQ, 1, 1); add(0, OP_BEQ, 1, 8);
    add(0, OP_J, 1, 0);   add(0, OP_J, 1, 1);   add(0, OP_J, 1, 11);
    // sw with three stall cycles in MEMWR
    add(0, OP_SW, 1, 0); add(0, OP_SW, 1, 1); add(0, OP_SW, 1, 2);
    add(0, OP_SW, 0, 5); add(0, OP_SW, 0, 5); add(0, OP_SW, 0, 5); add(0, OP_SW, 1, 5);
    // Illegal opcode
    add(0, OP_BAD, 1, 0); add(0, OP_BAD, 1, 1);
    // FETCH stall; mem_ready low and opcode changes in non-memory states are ignored
    add(0, OP_R, 0, 0); add(0, OP_R, 0, 0); add(0, OP_R, 1, 0);
    add(0, OP_R, 0, 1); add(0, OP_LW, 0, 6); add(0, OP_SW, 1, 7);
    // lw aborted by reset while waiting in MEMRD
    add(0, OP_LW, 1, 0); add(0, OP_LW, 1, 1); add(0, OP_LW, 1, 2);
    add(0, OP_LW, 0, 3); add(0, OP_LW, 0, 3); add(1, OP_LW, 0, 3); add(0, OP_LW, 0, 0);
    // 17 jumps: 4-bit counter wraps to 1
    for (int k = 0; k < 17; k++) begin
      add(0, OP_J, 1, 0); add(0, OP_J, 1, 1); add(0, OP_J, 1, 11);
    end

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      ctl_t c;
      @(posedge clk);
      #1;
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      c = exp_ctl(vecs[i].st, vecs[i].rdy, vecs[i].op);
      e.st = vecs[i].st; e.ctl = c; e.cnt = exp_cnt; e.idx = i;
      sb.push_back(e);
      if (vecs[i].rst) exp_cnt = 0;
      else if (c.retire) exp_cnt = exp_cnt + 1;
    end

    // Hand-written sw with a random-length stall
    n = int'($urandom_range(1, 4));
    @(posedge clk);
    #1;
    reset = 1'b0; opcode = OP_SW; mem_ready = 1'b1;
    cyc = 0;
    while (st != 4'd5 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sw_reach_memwr", 32'(st), 32'd5);
    mem_ready = 1'b0;
    we_cnt = 0; ret_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      we_cnt += int'(act.mem_we); ret_cnt += int'(act.retire);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    we_cnt += int'(act.mem_we); ret_cnt += int'(act.retire);
    @(posedge clk);
    #1;
    check("sw_mem_we_cycles", 32'(we_cnt), 32'(n + 1));
    check("sw_retire_pulses", 32'(ret_cnt), 32'd1);
    check("sw_back_to_fetch", 32'(st), 32'd0);
    check("sw_cnt32", cnt32, exp_cnt + 32'd1);
    check("sw_cnt4", 32'(cnt4), 32'((exp_cnt + 32'd1) & 32'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
